// File: rtl/gate_trigger_scheduler.sv
// gate_trigger_scheduler: round-robin, once-per-frame serializer of gate trigger pulses with quiet-period frame close
module gate_trigger_scheduler #(
  parameter int REQ_COUNT    = 4,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 logic_reset,
  input  logic                 frame_start,
  input  logic [REQ_COUNT-1:0] trig,
  output logic [REQ_COUNT-1:0] grant,
  output logic                 grant_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic [REQ_COUNT-1:0] fired,
  output logic                 suppressed
);
  localparam int PW = $clog2(REQ_COUNT);
  localparam int QW = QUIET_CYCLES > 1 ? $clog2(QUIET_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state, state_n;
  logic [REQ_COUNT-1:0]   pending, pending_n, fired_n, grant_n, pick, rot_oh;
  logic [2*REQ_COUNT-1:0] rot, spread;
  logic [PW-1:0]          ptr, ptr_n;
  logic [QW-1:0]          quiet_cnt, quiet_n;
  logic                   suppressed_n, hit;
  always_comb begin
    rot    = {pending, pending} >> ptr;
    rot_oh = '0;
    hit    = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (!hit && rot[k]) begin
        hit       = 1'b1;
        rot_oh[k] = 1'b1;
      end
    end
    spread = {{REQ_COUNT{1'b0}}, rot_oh} << ptr;
    pick   = spread[REQ_COUNT-1:0] | spread[2*REQ_COUNT-1:REQ_COUNT];
  end
  always_comb begin
    state_n      = state;
    pending_n    = pending;
    fired_n      = fired;
    suppressed_n = suppressed;
    ptr_n        = ptr;
    quiet_n      = quiet_cnt;
    grant_n      = '0;
    if (state == IDLE) begin
      if (frame_start) begin
        state_n      = RUN;
        pending_n    = '0;
        fired_n      = '0;
        suppressed_n = 1'b0;
        quiet_n      = '0;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end else begin
      pending_n    = (pending & ~pick) | (trig & ~fired);
      suppressed_n = suppressed | (|(trig & fired));
      if (hit) begin
        grant_n = pick;
        fired_n = fired | pick;
        quiet_n = '0;
        for (int j = 0; j < REQ_COUNT; j++) begin
          if (pick[j]) ptr_n = PW'((j + 1) % REQ_COUNT);
        end
      end else if (trig == '0) begin
        if (quiet_cnt == QW'(QUIET_CYCLES - 1)) state_n = DONE;
        else quiet_n = quiet_cnt + QW'(1);
      end else begin
        quiet_n = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (logic_reset) begin
      state      <= IDLE;
      pending    <= '0;
      fired      <= '0;
      suppressed <= 1'b0;
      ptr        <= '0;
      quiet_cnt  <= '0;
      grant      <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      fired      <= fired_n;
      suppressed <= suppressed_n;
      ptr        <= ptr_n;
      quiet_cnt  <= quiet_n;
      grant      <= grant_n;
    end
  end
  assign grant_valid = |grant;
  assign busy        = state == RUN;
  assign frame_done  = state == DONE;
endmodule

// File: tb/tb_gate_trigger_scheduler.sv
// tb_gate_trigger_scheduler: directed and randomized checks of gate_trigger_scheduler against a frame-level model
module tb_gate_trigger_scheduler;
  localparam int N  = 4;
  localparam int QC = 2;
  logic clk, logic_reset, frame_start, grant_valid, busy, frame_done, suppressed;
  logic [N-1:0] trig, grant, fired;
  logic [11:0] obs;
  int checks = 0;
  int passes = 0;
  int m_state, m_ptr, m_quiet;
  logic [N-1:0] m_pend, m_fired, m_grant;
  logic m_supp;
  gate_trigger_scheduler #(.REQ_COUNT(N), .QUIET_CYCLES(QC)) dut (
    .clk(clk), .logic_reset(logic_reset), .frame_start(frame_start), .trig(trig),
    .grant(grant), .grant_valid(grant_valid), .busy(busy), .frame_done(frame_done),
    .fired(fired), .suppressed(suppressed)
  );
  assign obs = {grant, grant_valid, busy, frame_done, fired, suppressed};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [11:0] exp_vec();
    return {m_grant, |m_grant, m_state == 1, m_state == 2, m_fired, m_supp};
  endfunction
  function automatic void model_step(input logic fs, input logic [N-1:0] tr, input logic rs);
    int win;
    logic [N-1:0] pend0, fired0;
    m_grant = '0;
    if (rs) begin
      m_state = 0; m_pend = '0; m_fired = '0; m_supp = 1'b0; m_ptr = 0; m_quiet = 0;
      return;
    end
    if (m_state == 0) begin
      if (fs) begin
        m_state = 1; m_pend = '0; m_fired = '0; m_supp = 1'b0; m_quiet = 0;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end else begin
      pend0 = m_pend; fired0 = m_fired; win = -1;
      for (int off = 0; off < N; off++)
        if (win < 0 && pend0[(m_ptr + off) % N]) win = (m_ptr + off) % N;
      if (win >= 0) begin
        m_pend[win] = 1'b0; m_grant[win] = 1'b1; m_fired[win] = 1'b1;
        m_ptr = (win + 1) % N; m_quiet = 0;
      end
      for (int i = 0; i < N; i++)
        if (tr[i]) begin
          if (fired0[i]) m_supp = 1'b1;
          else m_pend[i] = 1'b1;
        end
      if (win < 0) begin
        if (tr == '0) begin
          if (m_quiet == QC - 1) m_state = 2;
          else m_quiet++;
        end else m_quiet = 0;
      end
    end
  endfunction
  task automatic tick(input logic fs, input logic [N-1:0] tr, input logic rs);
    frame_start = fs; trig = tr; logic_reset = rs;
    @(posedge clk);
    model_step(fs, tr, rs);
    #1;
    frame_start = 1'b0; trig = '0; logic_reset = 1'b0;
  endtask
  task automatic test_reset();
    for (int e = 0; e < 2; e++) begin
      tick(1'b0, '0, 1'b1);
      checks++;
      if (obs !== 12'b0 || obs !== exp_vec())
        $display("FAIL reset c%0d: got %b expected %b", e, obs, 12'b0);
      else passes++;
    end
  endtask
  task automatic test_empty_frame();
    logic [3:0] b_exp = 4'b0011;
    logic [3:0] d_exp = 4'b0100;
    for (int e = 0; e < 4; e++) begin
      tick(e == 0, '0, 1'b0);
      checks++;
      if (obs !== exp_vec() || busy !== b_exp[e] || frame_done !== d_exp[e] || grant !== '0 || fired !== '0)
        $display("FAIL empty_frame e%0d: got %b expected %b busy %b done %b", e, obs, exp_vec(), b_exp[e], d_exp[e]);
      else passes++;
    end
  endtask
  task automatic test_burst(input logic retrig);
    int n = retrig ? 9 : 8;
    int done_e = retrig ? 7 : 6;
    logic [N-1:0] tr, g;
    for (int e = 0; e < n; e++) begin
      tr = e == 1 ? 4'b1011 : (retrig && e == 5) ? 4'b0010 : 4'b0000;
      g = e == 2 ? 4'b0001 : e == 3 ? 4'b0010 : e == 4 ? 4'b1000 : 4'b0000;
      tick(e == 0, tr, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== g || frame_done !== (e == done_e))
        $display("FAIL burst%0d e%0d: got %b expected %b grant %b", retrig, e, obs, exp_vec(), g);
      else passes++;
    end
    checks++;
    if (fired !== 4'b1011 || suppressed !== retrig)
      $display("FAIL burst%0d_flags: got fired %b supp %b expected fired 1011 supp %b", retrig, fired, suppressed, retrig);
    else passes++;
  endtask
  task automatic test_rotate();
    logic [N-1:0] g;
    for (int e = 0; e < 6; e++) begin
      tick(e == 0, e == 1 ? 4'b0010 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== (e == 2 ? 4'b0010 : 4'b0000))
        $display("FAIL rotate_prep e%0d: got %b expected %b", e, obs, exp_vec());
      else passes++;
    end
    for (int e = 0; e < 9; e++) begin
      g = e == 2 ? 4'b0100 : e == 3 ? 4'b1000 : e == 4 ? 4'b0001 : e == 5 ? 4'b0010 : 4'b0000;
      tick(e == 0, e == 1 ? 4'b1111 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== g || frame_done !== (e == 7))
        $display("FAIL rotate_all e%0d: got %b expected %b grant %b", e, obs, exp_vec(), g);
      else passes++;
    end
    for (int e = 0; e < 7; e++) begin
      g = e == 2 ? 4'b0100 : e == 3 ? 4'b0010 : 4'b0000;
      tick(e == 0, e == 1 ? 4'b0110 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== g)
        $display("FAIL rotate_ptr e%0d: got %b expected %b grant %b", e, obs, exp_vec(), g);
      else passes++;
    end
  endtask
  task automatic test_back_to_back();
    logic [N-1:0] g;
    for (int e = 0; e < 7; e++) begin
      g = e == 2 ? 4'b0001 : e == 3 ? 4'b0100 : 4'b0000;
      tick(e == 0, e == 1 ? 4'b0001 : e == 2 ? 4'b0100 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== g || suppressed !== 1'b0 || frame_done !== (e == 5))
        $display("FAIL back_to_back e%0d: got %b expected %b grant %b", e, obs, exp_vec(), g);
      else passes++;
    end
  endtask
  task automatic test_reset_mid();
    logic [N-1:0] g;
    tick(1'b1, '0, 1'b0);
    tick(1'b0, 4'b0110, 1'b0);
    for (int e = 0; e < 2; e++) begin
      tick(1'b0, '0, e == 0);
      checks++;
      if (obs !== 12'b0 || obs !== exp_vec())
        $display("FAIL reset_mid c%0d: got %b expected %b", e, obs, 12'b0);
      else passes++;
    end
    for (int e = 0; e < 7; e++) begin
      g = e == 2 ? 4'b0001 : e == 3 ? 4'b1000 : 4'b0000;
      tick(e == 0, e == 1 ? 4'b1001 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== g)
        $display("FAIL reset_ptr e%0d: got %b expected %b grant %b", e, obs, exp_vec(), g);
      else passes++;
    end
    for (int e = 0; e < 6; e++) begin
      tick(e == 0, e == 1 ? 4'b0100 : 4'b0000, 1'b0);
      checks++;
      if (obs !== exp_vec() || grant !== (e == 2 ? 4'b0100 : 4'b0000))
        $display("FAIL reset_after e%0d: got %b expected %b", e, obs, exp_vec());
      else passes++;
    end
  endtask
  task automatic test_random();
    logic [N-1:0] tr;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) tr[i] = $urandom_range(0, 3) == 0;
      tick($urandom_range(0, 5) == 0, tr, $urandom_range(0, 249) == 0);
      checks++;
      if (obs !== exp_vec())
        $display("FAIL random c%0d: got %b expected %b", c, obs, exp_vec());
      else passes++;
    end
  endtask
  initial begin
    frame_start = 1'b0; trig = '0; logic_reset = 1'b1;
    test_reset();
    test_empty_frame();
    test_burst(1'b0);
    test_burst(1'b1);
    test_rotate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gate_trigger_scheduler.md
# gate_trigger_scheduler

Serializes gate trigger events within one logic frame. Up to REQ_COUNT gate blocks (e.g. multi-input OR gates) post single-cycle trigger pulses. The scheduler grants at most one gate per cycle in round-robin order and lets each gate fire at most once per frame. It declares the frame finished after a configurable quiet period with no pending triggers.

## Interface
- REQ_COUNT, 4, number of requesting gates (≥2)
- QUIET_CYCLES, 2, consecutive idle RUN cycles required to close a frame (≥1)

- clk  in  1  system clock
- logic_reset  in  1  synchronous, active-high reset
- frame_start  in  1  pulse; opens a frame when in IDLE
- trig  in  REQ_COUNT  per-gate trigger pulses
- grant  out  REQ_COUNT  one-hot fire strobe, one cycle wide
- grant_valid  out  1  high when grant ≠ 0
- busy  out  1  high while state = RUN
- frame_done  out  1  one-cycle pulse on frame close
- fired  out  REQ_COUNT  mask of gates granted in the current or last frame
- suppressed  out  1  sticky per frame: a retrigger of an already-fired gate was dropped

## Operation
- States:
  - IDLE: waits for frame_start.
  - RUN: accepts triggers and issues grants.
  - DONE: one cycle, then returns to IDLE.
- Internal registers:
  - pending[REQ_COUNT]
  - ptr (round-robin start index, width clog2(REQ_COUNT))
  - quiet_cnt
- IDLE, frame_start=1: go to RUN.
  - Clear fired, pending, suppressed and quiet_cnt.
  - trig in the same cycle is ignored.
- IDLE or DONE: trig is ignored, with no flag. frame_start in RUN or DONE is ignored.
- RUN, at each edge:
  - For each i:
    - trig[i] & ~fired[i] sets pending[i]. A trigger on an already-pending bit merges with no effect.
    - trig[i] & fired[i] drops the trigger and sets suppressed.
  - If pending ≠ 0:
    - Select the first set pending bit, searching from ptr upward with wrap-around.
    - grant <= onehot(i), grant_valid <= 1.
    - Clear pending[i], set fired[i], ptr <= (i+1) mod REQ_COUNT.
    - quiet_cnt <= 0.
  - Else if trig = 0:
    - If quiet_cnt = QUIET_CYCLES-1, go to DONE.
    - Otherwise quiet_cnt++.
  - Else (trig ≠ 0, pending = 0): quiet_cnt <= 0.
- Arbitration uses registered pending only. A trig arriving in the same edge as a grant never competes in that edge.
- A gate granted at edge k that retriggers at edge k+1 or later is suppressed.
- ptr persists across frames. Only logic_reset clears it.
- fired and suppressed hold their values through DONE and IDLE until the next frame_start.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- grant and grant_valid are 0 in every cycle without a grant decision.

## Timing
- Reset values:
  - state IDLE
  - grant=0, grant_valid=0, busy=0, frame_done=0
  - fired=0, suppressed=0
  - pending=0, ptr=0, quiet_cnt=0
- logic_reset has priority over all inputs. Asserted mid-frame, all of the above values are present in the cycle after the reset edge, and pending triggers are discarded.
- frame_start sampled at edge e0: busy=1 from e0.
- Trigger latency:
  - trig sampled at edge k is latched into pending at edge k.
  - The earliest grant is visible after edge k+1.
  - Trigger-to-grant latency is therefore 2 cycles when the arbiter is uncontended.
- Throughput: one grant per cycle. N simultaneous triggers produce N grants on consecutive cycles.
- Frame close with no triggers: the frame opens at e0, and quiet edges e1…e_Q (Q = QUIET_CYCLES) follow.
  - State is DONE after e_Q, with busy=0 and frame_done=1.
  - State is IDLE after e_Q+1.
- Any trig during the quiet window restarts the quiet count.

## Test plan
All scenarios use REQ_COUNT=4 and QUIET_CYCLES=2.
1. Reset, then frame_start at e0 with no trig -> busy=1 after e0 and e1, frame_done=1 only after e2, grant stays 0, fired=0000.
2. frame_start at e0, trig=1011 at e1 -> grant=0001, 0010, 1000 after e2, e3, e4; fired=1011; ptr=0; frame_done after e6.
3. Same as scenario 2, plus trig=0010 at e5 -> no further grant, suppressed=1, quiet count restarts, frame_done after e7.
4. Second frame with ptr=2 left over, trig=1111 -> grant order 0100, 1000, 0001, 0010; final ptr=2.
5. trig=0001 at e1, trig=0100 at e2 (during grant of bit 0) -> grants 0001 then 0100 on consecutive cycles, no suppression.
6. logic_reset during a frame with pending=0110 -> next cycle: IDLE, all outputs 0, ptr=0. A new frame_start with trig=0100 then grants 0100 normally.
